// File: rtl/down_count_seq.sv
// ============================================================================
// Module   : down_count_seq
// Brief    : Handshake-driven programmable down-counter sequencer with load,
//            run, pause, terminal-count pulse, one-shot or auto-reload.
//            Optional prescaler enabled by defining DOWN_COUNT_SEQ_PRESCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_count_seq #(
    parameter int WIDTH        = 8,
    parameter int PRESCALE_DIV = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             auto_reload_i,
    input  logic             pause_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             done_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_n;
    logic             r_auto;
    logic             r_tc;
    logic             r_done;
    logic             w_tick;

`ifdef DOWN_COUNT_SEQ_PRESCALE_EN
    localparam int c_pre_w = (PRESCALE_DIV < 1) ? 1 : $clog2(PRESCALE_DIV + 1);
    localparam logic [c_pre_w-1:0] c_pre_top = c_pre_w'(PRESCALE_DIV);
    localparam logic [c_pre_w-1:0] c_pre_one = c_pre_w'(1);

    // The prescaler counts 0..DIV once after LOAD and 1..DIV thereafter, so the
    // first tick lands one cycle later than the rest (1 + (N+1)*DIV to DONE).
    logic [c_pre_w-1:0] r_pre;

    assign w_tick = (r_pre == c_pre_top);

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_pre <= '0;
        end else if (abort_i || r_state == S_LOAD) begin
            r_pre <= '0;
        end else if ((r_state == S_RUN || r_state == S_PAUSE) && !pause_i) begin
            r_pre <= w_tick ? c_pre_one : r_pre + c_pre_one;
        end
    end
`else
    // Every clock is a tick; the divide ratio only matters in the prescaled build.
    assign w_tick = (PRESCALE_DIV != 0) || 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= S_IDLE;
            r_count <= c_zero;
            r_n     <= c_zero;
            r_auto  <= 1'b0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tc   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_count <= c_zero;
                    if (start_i) begin
                        r_n     <= load_val_i;
                        r_auto  <= auto_reload_i;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort_i) begin
                        r_state <= S_IDLE;
                        r_count <= c_zero;
                    end else begin
                        r_count <= r_n;
                        r_state <= S_RUN;
                    end
                end
                // The release edge out of PAUSE counts like a RUN edge.
                S_RUN, S_PAUSE: begin
                    if (abort_i) begin
                        r_state <= S_IDLE;
                        r_count <= c_zero;
                    end else if (pause_i) begin
                        r_state <= S_PAUSE;
                    end else begin
                        r_state <= S_RUN;
                        if (w_tick) begin
                            if (r_count != c_zero) begin
                                r_count <= r_count - c_one;
                            end else begin
                                r_tc <= 1'b1;
                                if (r_auto) begin
                                    r_count <= r_n;
                                end else begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_count <= c_zero;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= c_zero;
                end
            endcase
        end
    end

    assign busy_o  = (r_state != S_IDLE);
    assign count_o = r_count;
    assign tc_o    = r_tc;
    assign done_o  = r_done;
    assign state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_down_count_seq.sv
// ============================================================================
// Module   : tb_down_count_seq
// Brief    : Self-checking bench for down_count_seq with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_down_count_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start_i;
    logic [WIDTH-1:0] load_val_i;
    logic             auto_reload_i;
    logic             pause_i;
    logic             abort_i;
    logic             busy_o;
    logic [WIDTH-1:0] count_o;
    logic             tc_o;
    logic             done_o;
    logic [2:0]       state_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    down_count_seq #(.WIDTH(WIDTH), .PRESCALE_DIV(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start_i),
        .load_val_i   (load_val_i),
        .auto_reload_i(auto_reload_i),
        .pause_i      (pause_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .count_o      (count_o),
        .tc_o         (tc_o),
        .done_o       (done_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: a phase name, the remaining count and the captured job.
    int m_phase = 0;   // 0 idle, 1 load, 2 run, 3 pause, 4 done
    int m_count = 0;
    int m_n     = 0;
    bit m_auto  = 0;
    bit m_tc    = 0;
    bit m_done  = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        m_valid = 1;
        m_tc = 0;
        m_done = 0;
        if (rstn) begin
            m_phase = 0; m_count = 0; m_n = 0; m_auto = 0;
        end else if (m_phase == 0) begin
            m_count = 0;
            if (start_i) begin
                m_n = int'(load_val_i); m_auto = auto_reload_i; m_phase = 1;
            end
        end else if (abort_i || m_phase == 4) begin
            m_phase = 0; m_count = 0;
        end else if (m_phase == 1) begin
            m_count = m_n; m_phase = 2;
        end else if (pause_i) begin
            m_phase = 3;
        end else begin
            m_phase = 2;
            if (m_count > 0) m_count = m_count - 1;
            else begin
                m_tc = 1;
                if (m_auto) m_count = m_n;
                else begin m_phase = 4; m_done = 1; end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_tests = n_tests + 1;
            if (int'(state_o) != m_phase || int'(count_o) != m_count ||
                busy_o != (m_phase != 0) || tc_o != m_tc || done_o != m_done) begin
                n_fail = n_fail + 1;
                $display("FAIL model cyc=%0d: dut st=%0d cnt=%0d busy=%0b tc=%0b done=%0b, exp st=%0d cnt=%0d busy=%0b tc=%0b done=%0b",
                         cyc, state_o, count_o, busy_o, tc_o, done_o,
                         m_phase, m_count, m_phase != 0, m_tc, m_done);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests = n_tests + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start_job(input int n, input bit auto_r, output int k);
        start_i = 1; load_val_i = WIDTH'(n); auto_reload_i = auto_r;
        @(negedge clk);
        k = cyc;
        start_i = 0; load_val_i = WIDTH'($urandom);
    endtask

    // Offset (in edges from the start edge) at which done_o is seen.
    task automatic wait_done(input int k, input int limit, output int off);
        off = -1;
        for (int i = 0; i < limit; i++) begin
            if (done_o) begin off = cyc - k; break; end
            @(negedge clk);
        end
        if (off < 0) begin
            n_tests = n_tests + 1; n_fail = n_fail + 1;
            $display("FAIL wait_done: timeout after %0d cycles, expected done", limit);
        end
    endtask

    initial begin
        int k, off, tcs, dones;
        rstn = 1; start_i = 1; load_val_i = 8'd9; auto_reload_i = 0;
        pause_i = 0; abort_i = 0;
        repeat (2) @(negedge clk);
        chk("reset_state", int'(state_o), 0);
        chk("reset_count", int'(count_o), 0);
        chk("reset_busy_tc_done", int'({busy_o, tc_o, done_o}), 0);
        rstn = 0; start_i = 0;
        @(negedge clk);

        // One-shot N=5
        start_job(5, 0, k);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk($sformatf("oneshot_count_k+%0d", i), int'(count_o), 6 - i);
        end
        @(negedge clk);
        chk("oneshot_tc_done_k+7", int'({tc_o, done_o}), 3);
        @(negedge clk);
        chk("oneshot_busy_k+8", int'(busy_o), 0);

        // Auto-reload N=3 over 12 cycles after LOAD exit
        start_job(3, 1, k);
        @(negedge clk);
        chk("auto_first_count", int'(count_o), 3);
        tcs = 0; dones = 0;
        repeat (12) begin
            @(negedge clk);
            tcs += int'(tc_o); dones += int'(done_o);
        end
        chk("auto_tc_pulses", tcs, 3);
        chk("auto_no_done", dones, 0);
        abort_i = 1; @(negedge clk); abort_i = 0;
        chk("auto_abort_idle", int'(state_o), 0);

        // Pause N=6 for three edges at count 4: done moves from k+8 to k+11
        start_job(6, 0, k);
        repeat (3) @(negedge clk);
        chk("pause_pre_count", int'(count_o), 4);
        pause_i = 1;
        repeat (3) begin
            @(negedge clk);
            chk("pause_hold", int'({state_o, count_o}), (3 << WIDTH) | 4);
        end
        pause_i = 0;
        wait_done(k, 40, off);
        chk("pause_done_offset", off, 11);
        @(negedge clk);

        // Abort at count 2
        start_job(5, 0, k);
        repeat (4) @(negedge clk);
        chk("abort_pre_count", int'(count_o), 2);
        abort_i = 1; @(negedge clk); abort_i = 0;
        chk("abort_result", int'({state_o, count_o, tc_o, done_o}), 0);
        @(negedge clk);
        chk("abort_quiet", int'({busy_o, tc_o, done_o}), 0);

        // Start/load changes while busy are ignored
        start_job(4, 0, k);
        @(negedge clk);
        start_i = 1; load_val_i = 8'd200;
        @(negedge clk);
        start_i = 0;
        chk("busy_start_ignored", int'(count_o), 3);
        wait_done(k, 40, off);
        chk("busy_start_done_offset", off, 6);
        @(negedge clk);

        // N=0 one-shot and N=255
        start_job(0, 0, k);
        wait_done(k, 10, off);
        chk("n0_done_offset", off, 2);
        chk("n0_tc", int'(tc_o), 1);
        @(negedge clk);
        start_job(255, 0, k);
        wait_done(k, 400, off);
        chk("n255_done_offset", off, 257);
        @(negedge clk);

        // Randomized traffic; the per-cycle compare checks it against the model
        for (int i = 0; i < 1500; i++) begin
            rstn          = ($urandom_range(0, 199) == 0);
            start_i       = ($urandom_range(0, 9) < 3);
            load_val_i    = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
            auto_reload_i = $urandom_range(0, 1);
            pause_i       = ($urandom_range(0, 9) < 2);
            abort_i       = ($urandom_range(0, 49) == 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/down_count_seq.md
Name: down_count_seq

Overview:
- Synchronous controller that sequences a programmable down-counter: load, run, pause, terminal-count detect, one-shot or auto-reload.
- Replaces ad-hoc ripple down-counters in the counters library with a single-clock, handshake-driven timer/sequencer.
- Upstream logic uses it for delays and periodic ticks.

Parameters:
- WIDTH, 8, counter and load-value width in bits (>=2).
- PRESCALE_DIV, 4, tick divide ratio; used only when the optional feature is compiled in (>=1).

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rstn  input  1  synchronous reset, active-high (asserted = 1), sampled on posedge clk.
- start_i  input  1  begin a count sequence; honoured only in IDLE.
- load_val_i  input  WIDTH  start/reload value N; captured when start_i is accepted.
- auto_reload_i  input  1  1 = reload N at terminal count and keep running; captured with start_i.
- pause_i  input  1  level: freeze counting while high.
- abort_i  input  1  terminate the sequence and return to IDLE.
- busy_o  output  1  high in every state except IDLE.
- count_o  output  WIDTH  current counter value.
- tc_o  output  1  one-cycle pulse at each terminal count.
- done_o  output  1  one-cycle pulse when a one-shot sequence completes.
- state_o  output  3  encoded FSM state: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.

Behaviour:
- Reset (rstn=1 at posedge): state IDLE; count_o=0, tc_o=0, done_o=0, busy_o=0; captured N=0, auto_reload=0. Reset overrides all inputs.
- Priority on each edge: rstn > abort_i > pause_i > count/terminal logic > start_i.
- IDLE: start_i=1 -> LOAD. Capture load_val_i and auto_reload_i. count_o holds 0.
- LOAD (one cycle): count_o<=N -> RUN.
- RUN, on each tick with pause_i=0:
  - count_o!=0: count_o<=count_o-1.
  - count_o==0: tc_o<=1 for one cycle. If auto_reload=1, count_o<=N and stay in RUN. If auto_reload=0, go to DONE with count_o held at 0.
- RUN with pause_i=1 -> PAUSE. Count holds, no decrement, no tc, even if count_o==0.
- PAUSE: count holds. pause_i=0 -> RUN; counting resumes on the next tick.
- DONE (one cycle): done_o=1 (Moore), then IDLE. tc_o and done_o are high in the same cycle.
- abort_i=1 in any non-IDLE state: go to IDLE, count_o<=0. No tc_o or done_o is generated. abort_i in IDLE has no effect.
- start_i outside IDLE is ignored. load_val_i changes after capture have no effect.
- Timing, one-shot, start accepted at edge k:
  - edge k+1: count_o=N.
  - edge k+1+N: count_o=0.
  - edge k+2+N: tc_o=1, done_o=1.
  - edge k+3+N: busy_o=0.
- Auto-reload period is N+1 ticks between tc_o pulses.
- N=0: LOAD sets 0; the first RUN tick raises tc_o. One-shot goes to DONE; auto-reload gives tc_o on every tick.
- N=2^WIDTH-1 is legal. There is no underflow: decrement never occurs from 0.
- Reset asserted mid-sequence: IDLE on that edge; outputs take reset values.

Optional Feature:
- Macro: DOWN_COUNT_SEQ_PRESCALE_EN.
- Defined: internal prescaler produces a tick once every PRESCALE_DIV clk cycles.
  - Prescaler is cleared in LOAD and on abort.
  - Prescaler is frozen in PAUSE.
  - RUN decrements and terminal counts occur only on ticks.
  - One-shot latency becomes 1 + (N+1)*PRESCALE_DIV cycles from LOAD exit to DONE entry.
- Undefined: tick=1 every cycle; PRESCALE_DIV is ignored; no prescaler flops.

Test Plan:
- Reset: rstn=1 for 2 cycles with start_i=1 -> state_o=0, count_o=0, busy_o=0, tc_o=0, done_o=0.
- One-shot, N=5, start at edge k -> count_o sequence 5,4,3,2,1,0 on edges k+1..k+6; tc_o=done_o=1 at edge k+7; busy_o=0 at k+8.
- Auto-reload, N=3, run 12 cycles -> tc_o pulses every 4 cycles, done_o never asserted, count_o cycles 3,2,1,0.
- Pause: N=6, pause_i high for 3 cycles when count_o=4 -> state_o=3, count_o stays 4; after release, decrement resumes; done is delayed by exactly 3 cycles versus the unpaused case.
- Abort and start during busy: abort_i at count_o=2 -> IDLE next edge, count_o=0, no tc_o or done_o. start_i pulsed in RUN -> ignored; load_val_i change has no effect.
- Edge values: N=0 one-shot -> tc_o/done_o 2 cycles after LOAD. N=255 (WIDTH=8) -> 256 RUN cycles. Prescale build, N=1, PRESCALE_DIV=4 -> done after 1+8 cycles from LOAD exit.
